// File: rtl/hazard_ctrl.sv
// Decode hazard controller: register scoreboard with RAW/WAW freeze and a post-redirect flush window.
// Freeze/flush are combinational from this cycle's inputs; scoreboard and flush counter update on CLK.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        inst_vld,
   input  logic        rs1_ren,
   input  logic        rs2_ren,
   input  logic [4:0]  rs1_p,
   input  logic [4:0]  rs2_p,
   input  logic [4:0]  rd_p,
   input  logic        rd_req,
   input  logic        ext_stall,
   input  logic        alu_redirect,
   input  logic        wb_vld,
   input  logic [4:0]  wb_rd,
   output logic        dec_freeze,
   output logic        alu_flush,
   output logic [31:0] sb_busy,
   output logic [3:0]  flush_cnt
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] sb_q, sb_d;
   logic        pend_vld_q, pend_vld_d;
   logic [4:0]  pend_rd_q, pend_rd_d;

   logic [31:0] wb_mask;
   logic [31:0] busy_eff;
   logic        raw1, raw2, waw;
   logic        issue;

   always_comb begin
      wb_mask = '0;
      if (wb_vld) wb_mask[wb_rd] = 1'b1;
      busy_eff = sb_q & ~wb_mask;

      raw1 = rs1_ren & (rs1_p != 5'd0) & busy_eff[rs1_p];
      raw2 = rs2_ren & (rs2_p != 5'd0) & busy_eff[rs2_p];
      waw  = rd_req  & (rd_p  != 5'd0) & busy_eff[rd_p];

      alu_flush  = alu_redirect | (state_q == FLUSH);
      dec_freeze = ext_stall | (inst_vld & ~alu_flush & (raw1 | raw2 | waw));
      issue      = inst_vld & ~dec_freeze & ~alu_flush;

      // Order encodes bit priority: squash clear > issue set > writeback clear.
      sb_d = sb_q;
      if (wb_vld) sb_d[wb_rd] = 1'b0;
      if (issue & rd_req) sb_d[rd_p] = 1'b1;
      if (alu_flush & pend_vld_q) sb_d[pend_rd_q] = 1'b0;
      sb_d[0] = 1'b0;

      pend_vld_d = 1'b0;
      pend_rd_d  = pend_rd_q;
      if (issue) begin
         pend_vld_d = rd_req & (rd_p != 5'd0);
         pend_rd_d  = rd_p;
      end else if (dec_freeze & ~alu_flush) begin
         pend_vld_d = pend_vld_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (alu_redirect && (FLUSH_CYCLES > 1)) begin
               state_d = FLUSH;
               cnt_d   = RELOAD;
            end
         end
         FLUSH: begin
            if (alu_redirect) begin
               cnt_d = RELOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= RUN;
         cnt_q      <= 4'd0;
         sb_q       <= '0;
         pend_vld_q <= 1'b0;
         pend_rd_q  <= 5'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sb_q       <= sb_d;
         pend_vld_q <= pend_vld_d;
         pend_rd_q  <= pend_rd_d;
      end
   end

   assign sb_busy   = sb_q;
   assign flush_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed sequences plus random traffic against a cycle-level model.
module tb_hazard_ctrl;

   localparam int FC = 2;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        inst_vld = 0, rs1_ren = 0, rs2_ren = 0, rd_req = 0;
   logic [4:0]  rs1_p = 0, rs2_p = 0, rd_p = 0, wb_rd = 0;
   logic        ext_stall = 0, alu_redirect = 0, wb_vld = 0;
   logic        dec_freeze, alu_flush;
   logic [31:0] sb_busy;
   logic [3:0]  flush_cnt;

   hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .CLK(CLK), .RSTN(RSTN), .inst_vld(inst_vld), .rs1_ren(rs1_ren), .rs2_ren(rs2_ren),
      .rs1_p(rs1_p), .rs2_p(rs2_p), .rd_p(rd_p), .rd_req(rd_req), .ext_stall(ext_stall),
      .alu_redirect(alu_redirect), .wb_vld(wb_vld), .wb_rd(wb_rd),
      .dec_freeze(dec_freeze), .alu_flush(alu_flush), .sb_busy(sb_busy), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        frz;
      logic        fl;
      logic [31:0] sb;
      logic [3:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model state: set of in-flight registers, the youngest issued writer still
   // in the decode output registers, and the first cycle after the flush window.
   logic [31:0] m_busy = '0;
   logic        m_pend = 1'b0;
   logic [4:0]  m_pend_rd = '0;
   int          m_flush_end = 0;
   int          cyc = 0;

   // Monitor: compares every cycle at the falling edge, and right after reset falls.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK or negedge RSTN);
         if (!RSTN) #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests += 4;
            if (dec_freeze !== e.frz) begin
               n_fail++;
               $display("FAIL dec_freeze cyc=%0d got=%b want=%b", cyc, dec_freeze, e.frz);
            end
            if (alu_flush !== e.fl) begin
               n_fail++;
               $display("FAIL alu_flush cyc=%0d got=%b want=%b", cyc, alu_flush, e.fl);
            end
            if (sb_busy !== e.sb) begin
               n_fail++;
               $display("FAIL sb_busy cyc=%0d got=%h want=%h", cyc, sb_busy, e.sb);
            end
            if (flush_cnt !== e.cnt) begin
               n_fail++;
               $display("FAIL flush_cnt cyc=%0d got=%0d want=%0d", cyc, flush_cnt, e.cnt);
            end
         end
      end
   end

   task automatic apply(input logic iv, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2,
                        input logic rdq, input logic [4:0] rd,
                        input logic ext, input logic redir,
                        input logic wbv, input logic [4:0] wbr);
      logic [31:0] eff, nb;
      logic        fl, haz, frz, iss;
      exp_t        e;
      inst_vld = iv; rs1_ren = r1e; rs1_p = r1; rs2_ren = r2e; rs2_p = r2;
      rd_req = rdq; rd_p = rd; ext_stall = ext; alu_redirect = redir;
      wb_vld = wbv; wb_rd = wbr;

      fl  = redir || (m_flush_end > cyc);
      eff = m_busy;
      if (wbv) eff[wbr] = 1'b0;
      haz = (r1e && r1 != 0 && eff[r1]) || (r2e && r2 != 0 && eff[r2]) ||
            (rdq && rd != 0 && eff[rd]);
      frz = ext || (iv && !fl && haz);
      e.frz = frz;
      e.fl  = fl;
      e.sb  = m_busy;
      e.cnt = (m_flush_end > cyc) ? 4'(m_flush_end - cyc) : 4'd0;
      exp_q.push_back(e);

      iss = iv && !frz && !fl;
      nb = m_busy;
      if (wbv) nb[wbr] = 1'b0;
      if (iss && rdq && rd != 0) nb[rd] = 1'b1;
      if (fl && m_pend) nb[m_pend_rd] = 1'b0;
      nb[0] = 1'b0;
      m_busy = nb;
      if (iss) begin
         m_pend = rdq && rd != 0;
         m_pend_rd = rd;
      end else if (fl || !frz) begin
         m_pend = 1'b0;
      end
      if (redir) m_flush_end = cyc + FC;
   endtask

   task automatic step();
      @(posedge CLK);
      cyc++;
      #1;
   endtask

   task automatic drive(input logic iv, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2,
                        input logic rdq, input logic [4:0] rd,
                        input logic ext, input logic redir,
                        input logic wbv, input logic [4:0] wbr);
      apply(iv, r1e, r1, r2e, r2, rdq, rd, ext, redir, wbv, wbr);
      step();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1 RSTN = 1'b1;
      idle(); idle();

      // RAW hold and release on x5
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      repeat (3) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 5);
      idle();

      // x0 write, then issue x7 alongside the writeback of an older x7
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
      idle();
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7);
      idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

      // Redirect squashes pending x9; hazarded decode during flush is not frozen
      drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
      drive(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0);
      drive(1, 1, 9, 0, 0, 1, 9, 0, 0, 0, 0);
      idle(); idle();

      // Back-to-back redirect
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(); idle(); idle();

      // Reset in the middle of a flush with a busy register
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #5;
      exp_q.push_back('{frz: 1'b0, fl: 1'b0, sb: 32'h0, cnt: 4'd0});
      RSTN = 1'b0;
      #2;
      RSTN = 1'b1;
      m_busy = '0; m_pend = 1'b0; m_flush_end = 0;
      step();
      idle();

      // Random traffic over a small register window so hazards are frequent
      for (int i = 0; i < 600; i++) begin
         logic [4:0] wr;
         wr = 5'($urandom_range(0, 7));
         drive(($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               (m_busy[wr] || $urandom_range(0, 9) == 0), wr);
      end
      idle();
      #10;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL queue_drain left=%0d want=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
